gt_bringup_sequencer: RTL and testbench

GT_BRINGUP_SEQUENCER -- requirements
Module: gt_bringup_sequencer

---
 rtl/gt_bringup_sequencer_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 26 ++
 rtl/gt_bringup_sequencer.sv | 136 +++++++++++++
 tb/tb_gt_bringup_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/gt_bringup_sequencer_pkg.sv
// Shared types and default timing for the transceiver bring-up sequencer.
// The state encoding is visible on the state output, so the values are fixed.
package gt_bringup_sequencer_pkg;

    typedef enum logic [2:0] {
        StResetAssert = 3'd0,
        StWaitPgood   = 3'd1,
        StWaitLink    = 3'd2,
        StRunning     = 3'd3,
        StFailed      = 3'd4
    } bringup_state_t;

    localparam int unsigned DefChannels    = 4;
    localparam int unsigned DefPgoodSettle = 65535;
    localparam int unsigned DefLinkTimeout = 125000000;
    localparam int unsigned DefMaxRetries  = 3;
    localparam int unsigned DefResetCycles = 16;

    // Every enabled lane reports good. An empty lane set never counts as good.
    function automatic logic all_good(input logic [15:0] status, input logic [15:0] enable);
        return (enable != 16'h0) && ((status & enable) == enable);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Per-bit two-flop synchroniser for quasi-static status inputs.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gt_bringup_sequencer.sv
// Sequences GT reset, power-good settling and link acquisition with bounded retries.
// All lane status inputs are synchronised before use; lane_en is assumed synchronous.
module gt_bringup_sequencer
    import gt_bringup_sequencer_pkg::*;
#(
    parameter int unsigned CHANNELS     = DefChannels,
    parameter int unsigned PGOOD_SETTLE = DefPgoodSettle,
    parameter int unsigned LINK_TIMEOUT = DefLinkTimeout,
    parameter int unsigned MAX_RETRIES  = DefMaxRetries,
    parameter int unsigned RESET_CYCLES = DefResetCycles
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] lane_en,
    input  logic [CHANNELS-1:0] pwrgood,
    input  logic [CHANNELS-1:0] link_up,
    input  logic                retry_req,
    output logic                gty_reset,
    output logic [CHANNELS-1:0] tx_clock_stable,
    output logic [CHANNELS-1:0] rx_clock_stable,
    output logic [2:0]          state,
    output logic [7:0]          retry_count,
    output logic                fail
);

    localparam int unsigned RstW    = $clog2(RESET_CYCLES + 1);
    localparam int unsigned SettleW = $clog2(PGOOD_SETTLE + 1);
    localparam int unsigned LinkW   = $clog2(LINK_TIMEOUT + 1);

    logic [CHANNELS-1:0] pg_sync;
    logic [CHANNELS-1:0] link_sync;

    sync_2ff #(.Width(CHANNELS)) u_sync_pwrgood (
        .clk (clk),
        .rst (rst),
        .d   (pwrgood),
        .q   (pg_sync)
    );

    sync_2ff #(.Width(CHANNELS)) u_sync_link_up (
        .clk (clk),
        .rst (rst),
        .d   (link_up),
        .q   (link_sync)
    );

    bringup_state_t      state_q, state_d;
    logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [SettleW-1:0]  settle_q, settle_d;
    logic [LinkW-1:0]    link_cnt_q, link_cnt_d;
    logic [7:0]          retry_q, retry_d, retry_inc;
    logic                gty_reset_q;
    logic [CHANNELS-1:0] stable_q;
    logic                fail_q;
    logic                pg_ok, link_ok;

    assign pg_ok     = all_good(16'(pg_sync), 16'(lane_en));
    assign link_ok   = all_good(16'(link_sync), 16'(lane_en));
    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    // Counters default to zero so each one starts clean on entry to its state.
    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = '0;
        settle_d   = '0;
        link_cnt_d = '0;
        retry_d    = retry_q;
        case (state_q)
            StResetAssert: begin
                if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) state_d = StWaitPgood;
                else rst_cnt_d = rst_cnt_q + RstW'(1);
            end
            StWaitPgood: begin
                if (pg_ok) begin
                    if (settle_q == SettleW'(PGOOD_SETTLE - 1)) state_d = StWaitLink;
                    else settle_d = settle_q + SettleW'(1);
                end
            end
            StWaitLink: begin
                if (lane_en == '0) begin
                    state_d = StWaitPgood;
                end else if (link_ok) begin
                    state_d = StRunning;
                end else if (link_cnt_q == LinkW'(LINK_TIMEOUT - 1)) begin
                    retry_d = retry_inc;
                    state_d = (MAX_RETRIES != 0 && 32'(retry_inc) >= MAX_RETRIES) ?
                              StFailed : StResetAssert;
                end else begin
                    link_cnt_d = link_cnt_q + LinkW'(1);
                end
            end
            StRunning: begin
                if (!pg_ok) state_d = StWaitPgood;
                else if (!link_ok) state_d = StWaitLink;
            end
            StFailed: begin
                if (retry_req) begin
                    retry_d = '0;
                    state_d = StResetAssert;
                end
            end
            default: state_d = StResetAssert;
        endcase
    end

    // Outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StResetAssert;
            rst_cnt_q   <= '0;
            settle_q    <= '0;
            link_cnt_q  <= '0;
            retry_q     <= '0;
            gty_reset_q <= 1'b1;
            stable_q    <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            settle_q    <= settle_d;
            link_cnt_q  <= link_cnt_d;
            retry_q     <= retry_d;
            gty_reset_q <= (state_d == StResetAssert) || (state_d == StFailed);
            stable_q    <= (state_d == StWaitLink || state_d == StRunning) ? lane_en : '0;
            fail_q      <= (state_d == StFailed);
        end
    end

    assign gty_reset       = gty_reset_q;
    assign tx_clock_stable = stable_q;
    assign rx_clock_stable = stable_q;
    assign state           = state_q;
    assign retry_count     = retry_q;
    assign fail            = fail_q;

endmodule

// File: tb/tb_gt_bringup_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle offset
// from an anchor; the monitor checks each observed output change against the queue.
module tb_gt_bringup_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] lane_en;
    logic [3:0] pwrgood;
    logic [3:0] link_up;
    logic       retry_req;
    logic       gty_reset;
    logic [3:0] tx_clock_stable;
    logic [3:0] rx_clock_stable;
    logic [2:0] state;
    logic [7:0] retry_count;
    logic       fail;

    gt_bringup_sequencer #(
        .CHANNELS     (4),
        .PGOOD_SETTLE (16),
        .LINK_TIMEOUT (100),
        .MAX_RETRIES  (2),
        .RESET_CYCLES (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .lane_en         (lane_en),
        .pwrgood         (pwrgood),
        .link_up         (link_up),
        .retry_req       (retry_req),
        .gty_reset       (gty_reset),
        .tx_clock_stable (tx_clock_stable),
        .rx_clock_stable (rx_clock_stable),
        .state           (state),
        .retry_count     (retry_count),
        .fail            (fail)
    );

    typedef struct {
        string       name;
        logic [20:0] obs;
        int          dly;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          anchor   = 0;
    logic [20:0] prev_obs = 'x;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed tuple: {state, gty_reset, tx_stable, rx_stable, retry_count, fail}.
    always @(negedge clk) begin
        logic [20:0] obs;
        exp_t        e;
        obs = {state, gty_reset, tx_clock_stable, rx_clock_stable, retry_count, fail};
        if (obs !== prev_obs) begin
            prev_obs = obs;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change got obs=%h at dly=%0d, want no change",
                         obs, cyc - anchor);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e.obs || (e.dly >= 0 && (cyc - anchor) != e.dly)) begin
                    failures++;
                    $display("FAIL %s got obs=%h dly=%0d, want obs=%h dly=%0d",
                             e.name, obs, cyc - anchor, e.obs, e.dly);
                end
            end
        end
    end

    task automatic expect_obs(input string name, input logic [2:0] st, input logic gty,
                              input logic [3:0] stab, input logic [7:0] rc, input logic fl,
                              input int dly);
        exp_t e;
        e.name = name;
        e.obs  = {st, gty, stab, stab, rc, fl};
        e.dly  = dly;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        lane_en   = 4'hF;
        pwrgood   = 4'hF;
        link_up   = 4'hF;
        retry_req = 1'b0;
        expect_obs("reset_state", 3'd0, 1'b1, 4'h0, 8'd0, 1'b0, -1);
        #1 rst = 1'b1;
        tick(3);

        // Power-up: 16 reset cycles, 16 settle cycles, then link already up.
        anchor = cyc;
        expect_obs("rst_release_wait_pgood", 3'd1, 1'b0, 4'h0, 8'd0, 1'b0, 16);
        expect_obs("settled_wait_link",      3'd2, 1'b0, 4'hF, 8'd0, 1'b0, 32);
        expect_obs("first_running",          3'd3, 1'b0, 4'hF, 8'd0, 1'b0, 33);
        rst = 1'b0;
        tick(40);

        // Simultaneous pwrgood and link drop: pwrgood wins.
        anchor = cyc;
        expect_obs("dual_drop_wait_pgood", 3'd1, 1'b0, 4'h0, 8'd0, 1'b0, 3);
        pwrgood = 4'hB;
        link_up = 4'hD;
        tick(10);

        // One-cycle pwrgood glitch at settle count 10 restarts settling.
        anchor = cyc;
        expect_obs("glitch_wait_link", 3'd2, 1'b0, 4'hF, 8'd0, 1'b0, 29);
        expect_obs("glitch_running",   3'd3, 1'b0, 4'hF, 8'd0, 1'b0, 30);
        pwrgood = 4'hF;
        link_up = 4'hF;
        tick(10);
        pwrgood = 4'hE;
        tick(1);
        pwrgood = 4'hF;
        tick(30);

        // retry_req outside FAILED must not disturb anything.
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
        tick(3);

        // Narrow lane set with lanes 2/3 dead, then widen it.
        anchor = cyc;
        expect_obs("lanes3_running", 3'd3, 1'b0, 4'h3, 8'd0, 1'b0, 1);
        lane_en = 4'h3;
        pwrgood = 4'h3;
        link_up = 4'h3;
        tick(5);
        anchor = cyc;
        expect_obs("lanes7_wait_pgood", 3'd1, 1'b0, 4'h0, 8'd0, 1'b0, 1);
        lane_en = 4'h7;
        tick(5);
        anchor = cyc;
        expect_obs("lanes3_wait_link", 3'd2, 1'b0, 4'h3, 8'd0, 1'b0, 16);
        expect_obs("lanes3_rerun",     3'd3, 1'b0, 4'h3, 8'd0, 1'b0, 17);
        lane_en = 4'h3;
        tick(25);

        // Link stuck down: two timeouts then FAILED.
        anchor = cyc;
        expect_obs("link_drop_wait_link", 3'd2, 1'b0, 4'h3, 8'd0, 1'b0, 3);
        expect_obs("timeout1_reset",      3'd0, 1'b1, 4'h0, 8'd1, 1'b0, 103);
        expect_obs("retry1_wait_pgood",   3'd1, 1'b0, 4'h0, 8'd1, 1'b0, 119);
        expect_obs("retry1_wait_link",    3'd2, 1'b0, 4'h3, 8'd1, 1'b0, 135);
        expect_obs("timeout2_failed",     3'd4, 1'b1, 4'h0, 8'd2, 1'b1, 235);
        link_up = 4'h0;
        tick(245);
        pwrgood = 4'h0;
        tick(5);
        pwrgood = 4'h3;
        tick(3);

        // retry_req leaves FAILED; then rst mid WAIT_LINK aborts in the same cycle.
        anchor = cyc;
        expect_obs("retry_req_reset",   3'd0, 1'b1, 4'h0, 8'd0, 1'b0, 1);
        expect_obs("retry_wait_pgood",  3'd1, 1'b0, 4'h0, 8'd0, 1'b0, 17);
        expect_obs("retry_wait_link",   3'd2, 1'b0, 4'h3, 8'd0, 1'b0, 33);
        expect_obs("async_rst_abort",   3'd0, 1'b1, 4'h0, 8'd0, 1'b0, 40);
        retry_req = 1'b1;
        tick(1);
        retry_req = 1'b0;
        tick(39);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d want=0 (next %s)", exp_q.size(),
                     exp_q[0].name);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
